// File: rtl/wide_alu_seq.sv
// wide_alu_seq: 16-bit ADD/RSH/XOR/AND/CMP done as two byte
// passes through an external 8-bit combinational ALU.
package wide_alu_pkg;
  localparam logic [3:0] kADD = 4'b01_00;
  localparam logic [3:0] kRSH = 4'b01_01;
  localparam logic [3:0] kXOR = 4'b10_00;
  localparam logic [3:0] kAND = 4'b10_01;
  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_RSH = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_AND = 3'd3;
  localparam logic [2:0] CMD_CMP = 3'd4;
endpackage

module wide_alu_seq
  import wide_alu_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        cin,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        err,
  output logic        busy,
  output logic        done,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_funct,
  output logic        alu_sc_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_sc_out,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    IDLE, FIRST, SECOND, DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  cmd_q;
  logic [15:0] opa_q, opb_q;
  logic        cin_q;
  logic [7:0]  byte_q;
  logic        sc_q, z_q;
  logic [15:0] result_q;
  logic        cout_q, zero_q, err_q;

  logic is_add, is_rsh, is_and, hi;
  logic legal;
  logic [3:0] opf;

  assign is_add = (cmd_q == CMD_ADD);
  assign is_rsh = (cmd_q == CMD_RSH);
  assign is_and = (cmd_q == CMD_AND);
  assign legal  = (cmd <= CMD_CMP);
  assign hi     = (state_q == SECOND);

  // Drives decode only from state and latched operands.
  always_comb begin
    opf       = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sc_in = 1'b0;
    if (state_q == FIRST || state_q == SECOND) begin
      unique case (1'b1)
        is_add: begin
          opf       = kADD;
          alu_a     = hi ? opa_q[15:8] : opa_q[7:0];
          alu_b     = hi ? opb_q[15:8] : opb_q[7:0];
          alu_sc_in = hi ? sc_q : cin_q;
        end
        is_rsh: begin
          opf       = kRSH;
          alu_a     = hi ? opa_q[7:0] : opa_q[15:8];
          alu_sc_in = hi ? sc_q : cin_q;
        end
        is_and: begin
          opf   = kAND;
          alu_a = hi ? opa_q[15:8] : opa_q[7:0];
          alu_b = hi ? opb_q[15:8] : opb_q[7:0];
        end
        default: begin
          opf   = kXOR;
          alu_a = hi ? opa_q[15:8] : opa_q[7:0];
          alu_b = hi ? opb_q[15:8] : opb_q[7:0];
        end
      endcase
    end
  end

  assign alu_op    = opf[3:2];
  assign alu_funct = opf[1:0];

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      byte_q   <= '0;
      sc_q     <= 1'b0;
      z_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cmd_q <= cmd;
            opa_q <= opa;
            opb_q <= opb;
            cin_q <= cin;
            if (legal) begin
              err_q   <= 1'b0;
              state_q <= FIRST;
            end else begin
              err_q    <= 1'b1;
              result_q <= '0;
              cout_q   <= 1'b0;
              zero_q   <= 1'b1;
              state_q  <= DONE;
            end
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        FIRST: begin
          byte_q  <= alu_out;
          sc_q    <= alu_sc_out;
          z_q     <= alu_zero;
          state_q <= SECOND;
        end
        SECOND: begin
          // RSH walks high byte first, the rest low byte first.
          result_q <= is_rsh ? {byte_q, alu_out}
                             : {alu_out, byte_q};
          cout_q   <= (is_add | is_rsh) & alu_sc_out;
          zero_q   <= z_q & alu_zero;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign err    = err_q;
  assign busy   = (state_q == FIRST) || (state_q == SECOND);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_wide_alu_seq.sv
// tb_wide_alu_seq: scoreboard bench with an 8-bit ALU model
// wired to the sequencer's alu_* ports.
module tb_wide_alu_seq;
  import wide_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [2:0]  cmd;
  logic [15:0] opa, opb;
  logic        cin;
  logic [15:0] result;
  logic        cout, zero, err, busy, done;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_op, alu_funct;
  logic        alu_sc_in, alu_sc_out, alu_zero;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  wide_alu_seq dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start),
    .cmd(cmd), .opa(opa), .opb(opb), .cin(cin),
    .result(result), .cout(cout), .zero(zero),
    .err(err), .busy(busy), .done(done),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_funct(alu_funct),
    .alu_sc_in(alu_sc_in), .alu_out(alu_out),
    .alu_sc_out(alu_sc_out), .alu_zero(alu_zero)
  );

  always_comb begin
    alu_out    = '0;
    alu_sc_out = 1'b0;
    case ({alu_op, alu_funct})
      kADD: {alu_sc_out, alu_out} = {1'b0, alu_a}
              + {1'b0, alu_b} + {8'd0, alu_sc_in};
      kRSH: begin
        alu_out    = {alu_sc_in, alu_a[7:1]};
        alu_sc_out = alu_a[0];
      end
      kXOR: alu_out = alu_a ^ alu_b;
      kAND: alu_out = alu_a & alu_b;
      default: ;
    endcase
  end
  assign alu_zero = (alu_out == 8'd0);

  function automatic exp_t model(input logic [2:0] c,
    input logic [15:0] a, input logic [15:0] b,
    input logic ci);
    exp_t e;
    logic [16:0] s;
    e = '0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.r = s[15:0];
        e.c = s[16];
      end
      3'd1: begin
        e.r = {ci, a[15:1]};
        e.c = a[0];
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = a & b;
      3'd4: e.r = a ^ b;
      default: e.e = 1'b1;
    endcase
    e.z = (e.r == 16'd0);
    return e;
  endfunction

  task automatic launch(input logic [2:0] c,
    input logic [15:0] a, input logic [15:0] b,
    input logic ci);
    start = 1'b1;
    cmd = c;
    opa = a;
    opb = b;
    cin = ci;
    sb.push_back(model(c, a, b, ci));
    @(negedge CLK);
    start = 1'b0;
    cmd = 3'($urandom);
    opa = 16'($urandom);
    opb = 16'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 8) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    start = 1'b1;
    cmd = CMD_ADD;
    opa = 16'h1234;
    opb = 16'h1111;
    cin = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({result, cout, zero, err, busy, done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outs got %h/%b%b%b%b%b want 0",
        result, cout, zero, err, busy, done);
    end
    vectors++;
    if ({alu_a, alu_b, alu_op, alu_funct, alu_sc_in}
        !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_alu got %h %h %b %b %b want 0",
        alu_a, alu_b, alu_op, alu_funct, alu_sc_in);
    end
    Reset_n = 1'b1;
    launch(CMD_ADD, 16'h0102, 16'h0304, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_accept busy=%b want 1", busy);
    end
    begin
      int cyc;
      exp_t e;
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (result !== e.r) begin
        miscompares++;
        $display("FAIL first_edge_result got %h want %h",
          result, e.r);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_add;
    logic [15:0] ta[3] = '{16'h00FF, 16'hFFFF, 16'h1234};
    logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        tc[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int cyc;
      exp_t e;
      launch(CMD_ADD, ta[i], tb[i], tc[i]);
      wait_done(cyc);
      vectors++;
      if (cyc !== 3) begin
        miscompares++;
        $display("FAIL add_latency[%0d] got %0d want 3", i, cyc);
      end
      e = sb.pop_front();
      vectors++;
      if ({result, cout, zero, err} !== e) begin
        miscompares++;
        $display("FAIL add[%0d] got %h c%b z%b e%b want %h c%b z%b e%b",
          i, result, cout, zero, err, e.r, e.c, e.z, e.e);
      end
      @(negedge CLK);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL add_done_pulse[%0d] done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_rsh;
    logic [15:0] ta[3] = '{16'h8001, 16'h0002, 16'h5A5B};
    logic        tc[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      int cyc;
      exp_t e;
      launch(CMD_RSH, ta[i], 16'hFFFF, tc[i]);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 3 || {result, cout, zero, err} !== e) begin
        miscompares++;
        $display("FAIL rsh[%0d] cyc %0d got %h c%b z%b want %h c%b z%b",
          i, cyc, result, cout, zero, e.r, e.c, e.z);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_logic_cmp;
    logic [2:0]  tm[5] = '{CMD_XOR, CMD_AND, CMD_CMP,
                           CMD_CMP, CMD_AND};
    logic [15:0] ta[5] = '{16'hF0F0, 16'hF0F0, 16'h1234,
                           16'h1234, 16'h0F0F};
    logic [15:0] tb[5] = '{16'h0FF0, 16'h0FF0, 16'h1234,
                           16'h1235, 16'hF0F0};
    for (int i = 0; i < 5; i++) begin
      int cyc;
      exp_t e;
      launch(tm[i], ta[i], tb[i], 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 3 || {result, cout, zero, err} !== e) begin
        miscompares++;
        $display("FAIL logic[%0d] cyc %0d got %h c%b z%b want %h c%b z%b",
          i, cyc, result, cout, zero, e.r, e.c, e.z);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    exp_t e;
    logic [15:0] prev;
    prev = result;
    launch(CMD_ADD, 16'h1111, 16'h2222, 1'b0);
    start = 1'b1;
    cmd = CMD_AND;
    opa = 16'hAAAA;
    opb = 16'h5555;
    vectors++;
    if (busy !== 1'b1 || result !== prev) begin
      miscompares++;
      $display("FAIL busy_hold busy=%b res=%h want 1 %h",
        busy, result, prev);
    end
    @(negedge CLK);
    start = 1'b0;
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 2 || result !== e.r) begin
      miscompares++;
      $display("FAIL busy_ignore cyc %0d got %h want %h",
        cyc, result, e.r);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int cyc;
    exp_t e;
    launch(CMD_XOR, 16'h00FF, 16'hFF00, 1'b0);
    wait_done(cyc);
    void'(sb.pop_front());
    launch(CMD_ADD, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 3 || {result, cout, zero, err} !== e) begin
      miscompares++;
      $display("FAIL back_to_back cyc %0d got %h want %h",
        cyc, result, e.r);
    end
    @(negedge CLK);
  endtask

  task automatic test_abort;
    int seen;
    launch(CMD_ADD, 16'h4444, 16'h1111, 1'b1);
    @(negedge CLK);
    Reset_n = 1'b0;
    @(negedge CLK);
    void'(sb.pop_back());
    vectors++;
    if ({result, cout, zero, err, busy, done, alu_a, alu_b,
         alu_op, alu_funct, alu_sc_in} !== 42'd0) begin
      miscompares++;
      $display("FAIL abort_outs res=%h busy=%b done=%b want 0",
        result, busy, done);
    end
    Reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done saw %0d want 0", seen);
    end
  endtask

  task automatic test_illegal;
    int cyc;
    exp_t e;
    launch(3'b111, 16'hBEEF, 16'h1234, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 1 || {result, cout, zero, err} !== e) begin
      miscompares++;
      $display("FAIL illegal cyc %0d got %h c%b z%b e%b want %h 0 1 1",
        cyc, result, cout, zero, err, e.r);
    end
    @(negedge CLK);
    launch(CMD_ADD, 16'h0010, 16'h0020, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (err !== 1'b0 || result !== e.r) begin
      miscompares++;
      $display("FAIL err_clear err=%b res=%h want 0 %h",
        err, result, e.r);
    end
    @(negedge CLK);
  endtask

  initial begin
    Reset_n = 1'b0;
    start = 1'b0;
    cmd = '0;
    opa = '0;
    opb = '0;
    cin = 1'b0;
    @(negedge CLK);
    test_reset;
    test_add;
    test_rsh;
    test_logic_cmp;
    test_busy_ignore;
    test_back_to_back;
    test_abort;
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
